sram_stage_sequencer: RTL

// - Top-level SRAM owner/sequencer: grants the single SRAM port to display (idle), UART receiver, then NUM_STAGES decode stages in order.
// - Generalises the fixed UART->milestone->display flow to N stages, each with a start/done handshake.
// - Adds per-stage skip and an optional watchdog.
// - All SRAM muxing derives from registered state; no procedural assigns.

---
 rtl/sram_stage_sequencer.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sram_stage_sequencer.sv
// ---------------------------------------------------------------------------
// sram_stage_sequencer
//
// Owns the single SRAM port and hands it out in a fixed order. The display
// holds it while idle. A UART start bit hands it to the UART receiver until the
// line has been quiet for TIMEOUT_CYCLES. After that, NUM_STAGES processing
// stages get it one after another. Each stage uses a start/done handshake, and
// any stage can be bypassed with its skip bit.
//
// Optional feature macro: STAGE_WATCHDOG_EN
//   When this macro is defined, a stage that runs for WATCHDOG_CYCLES without
//   raising done is abandoned. The sequencer returns to idle and sets the
//   sticky watchdog_error flag. When it is undefined, stages may run for any
//   length of time and watchdog_error is tied low.
//
// Ports
//   Clock, Resetn       clock, asynchronous active-low reset
//   UART_RX_I           UART line; a low level while idle is a start bit
//   UART_we_n           UART write strobe (active low), UART_address, UART_write_data
//   VGA_address         display read address
//   stage_address       packed per-stage addresses, stage i at [i*ADDR_W +: ADDR_W]
//   stage_write_data    packed per-stage data, stage i at [i*DATA_W +: DATA_W]
//   stage_we_n          per-stage write enable (active low)
//   stage_done          per-stage completion, stage_skip per-stage bypass
//   stage_start         one-hot start, held high while that stage runs
//   UART_rx_initialize  1-cycle pulse on start-bit detection
//   UART_rx_enable      1-cycle pulse in the cycle after initialize
//   VGA_enable          high only while idle
//   SRAM_address, SRAM_write_data, SRAM_we_n   muxed SRAM port
//   current_stage       index of the active or next stage
//   busy                high whenever not idle
//   sequence_done       1-cycle pulse when the last stage completes or is skipped
//   watchdog_error      sticky stage-timeout flag
// ---------------------------------------------------------------------------
module sram_stage_sequencer #(
    parameter int ADDR_W          = 18,
    parameter int DATA_W          = 16,
    parameter int NUM_STAGES      = 3,
    parameter int TIMEOUT_CYCLES  = 50000000,
    parameter int WATCHDOG_CYCLES = 16777216,
    localparam int SIDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                         Clock,
    input  logic                         Resetn,
    input  logic                         UART_RX_I,
    input  logic                         UART_we_n,
    input  logic [ADDR_W-1:0]            UART_address,
    input  logic [DATA_W-1:0]            UART_write_data,
    input  logic [ADDR_W-1:0]            VGA_address,
    input  logic [NUM_STAGES*ADDR_W-1:0] stage_address,
    input  logic [NUM_STAGES*DATA_W-1:0] stage_write_data,
    input  logic [NUM_STAGES-1:0]        stage_we_n,
    input  logic [NUM_STAGES-1:0]        stage_done,
    input  logic [NUM_STAGES-1:0]        stage_skip,
    output logic [NUM_STAGES-1:0]        stage_start,
    output logic                         UART_rx_initialize,
    output logic                         UART_rx_enable,
    output logic                         VGA_enable,
    output logic [ADDR_W-1:0]            SRAM_address,
    output logic [DATA_W-1:0]            SRAM_write_data,
    output logic                         SRAM_we_n,
    output logic [SIDX_W-1:0]            current_stage,
    output logic                         busy,
    output logic                         sequence_done,
    output logic                         watchdog_error
);

    // Reception and stage execution never overlap. One counter therefore
    // serves as both the UART idle timer and the stage watchdog, and it is
    // sized for the larger of the two limits.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > WATCHDOG_CYCLES) ? TIMEOUT_CYCLES : WATCHDOG_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SIDX_W-1:0] LAST_STAGE   = SIDX_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_UART_RX,
        S_STAGE_ENTER,
        S_STAGE_RUN
    } state_t;

    state_t                state, next_state;
    logic [CNT_W-1:0]      timer, next_timer;
    logic [SIDX_W-1:0]     next_stage;
    logic [NUM_STAGES-1:0] next_start;
    logic                  next_init;
    logic                  next_enable;
    logic                  next_seq_done;
    logic                  next_wd_error;

    // State register. Every output except the SRAM mux, busy and VGA_enable
    // is registered here, so downstream logic never sees combinational glitches.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state              <= S_IDLE;
            timer              <= '0;
            current_stage      <= '0;
            stage_start        <= '0;
            UART_rx_initialize <= 1'b0;
            UART_rx_enable     <= 1'b0;
            sequence_done      <= 1'b0;
        end else begin
            state              <= next_state;
            timer              <= next_timer;
            current_stage      <= next_stage;
            stage_start        <= next_start;
            UART_rx_initialize <= next_init;
            UART_rx_enable     <= next_enable;
            sequence_done      <= next_seq_done;
        end
    end

`ifdef STAGE_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WATCHDOG_CYCLES - 1);

    // Sticky error flag; only reset clears it.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            watchdog_error <= 1'b0;
        end else begin
            watchdog_error <= next_wd_error;
        end
    end
`else
    assign watchdog_error = 1'b0;
`endif

    // Next-state logic. Pulses default to low, and start is held until the
    // running stage reports done. A skipped or completed final stage returns
    // to idle with stage index 0 and pulses sequence_done.
    always_comb begin
        next_state    = state;
        next_timer    = timer;
        next_stage    = current_stage;
        next_start    = stage_start;
        next_init     = 1'b0;
        next_enable   = 1'b0;
        next_seq_done = 1'b0;
        next_wd_error = watchdog_error;

        case (state)
            S_IDLE: begin
                if (!UART_RX_I) begin
                    next_state = S_UART_RX;
                    next_init  = 1'b1;
                    next_timer = '0;
                end
            end

            S_UART_RX: begin
                next_enable = UART_rx_initialize;
                // The timeout check comes first, so a write strobe in the
                // expiry cycle cannot extend reception.
                if (timer == TIMEOUT_LAST) begin
                    next_timer = '0;
                    next_stage = '0;
                    next_state = S_STAGE_ENTER;
                end else if (!UART_we_n) begin
                    next_timer = '0;
                end else begin
                    next_timer = timer + CNT_W'(1);
                end
            end

            S_STAGE_ENTER: begin
                next_timer = '0;
                if (stage_skip[current_stage]) begin
                    if (current_stage == LAST_STAGE) begin
                        next_state    = S_IDLE;
                        next_stage    = '0;
                        next_seq_done = 1'b1;
                    end else begin
                        next_stage = current_stage + SIDX_W'(1);
                    end
                end else begin
                    next_start = NUM_STAGES'(1) << current_stage;
                    next_state = S_STAGE_RUN;
                end
            end

            S_STAGE_RUN: begin
                // Only the running stage's done bit matters. Done takes
                // priority over watchdog expiry in the same cycle.
                if (stage_done[current_stage]) begin
                    next_start = '0;
                    if (current_stage == LAST_STAGE) begin
                        next_state    = S_IDLE;
                        next_stage    = '0;
                        next_seq_done = 1'b1;
                    end else begin
                        next_stage = current_stage + SIDX_W'(1);
                        next_state = S_STAGE_ENTER;
                    end
                end
`ifdef STAGE_WATCHDOG_EN
                else if (timer == WD_LAST) begin
                    next_start    = '0;
                    next_state    = S_IDLE;
                    next_stage    = '0;
                    next_timer    = '0;
                    next_wd_error = 1'b1;
                end else begin
                    next_timer = timer + CNT_W'(1);
                end
`endif
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    assign busy       = (state != S_IDLE);
    assign VGA_enable = (state == S_IDLE);

    // SRAM port mux. It is selected purely from registered state. Idle and
    // stage-enter cycles both present the display address with writes off.
    always_comb begin
        SRAM_address    = VGA_address;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        case (state)
            S_UART_RX: begin
                SRAM_address    = UART_address;
                SRAM_write_data = UART_write_data;
                SRAM_we_n       = UART_we_n;
            end
            S_STAGE_RUN: begin
                SRAM_address    = stage_address[current_stage*ADDR_W +: ADDR_W];
                SRAM_write_data = stage_write_data[current_stage*DATA_W +: DATA_W];
                SRAM_we_n       = stage_we_n[current_stage];
            end
            default: begin
                SRAM_we_n = 1'b1;
            end
        endcase
    end

endmodule
